// File: rtl/sma_pkg.sv
// Shared constants and context record for the multi-channel SMA scheduler.
// Holds the default geometry (channels, sample width, window), the widths
// derived from it, and the per-channel scalar context struct.
package sma_pkg;

  localparam int unsigned DEF_NUM_CH     = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_WINDOW     = 4;

  localparam int unsigned CH_W   = $clog2(DEF_NUM_CH);
  localparam int unsigned PTR_W  = $clog2(DEF_WINDOW);
  localparam int unsigned SUM_W  = DEF_DATA_WIDTH + PTR_W;
  localparam int unsigned FILL_W = $clog2(DEF_WINDOW + 1);

  // Scalar per-channel context; the history ring is kept separately.
  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [PTR_W-1:0]  wptr;
    logic [FILL_W-1:0] fill;
  } ch_ctx_t;

endpackage

// File: rtl/sma_rr_arb.sv
// Round-robin arbiter.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   req        - request vector
//   advance    - grant was taken; move priority past the winner
//   grant_c    - one-hot grant (combinational)
//   idx_c      - encoded index of the grant (combinational)
module sma_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant_c,
  output logic [$clog2(N)-1:0] idx_c
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] rr_ptr;
  logic [IW:0]   cand;
  logic          found;

  // Scan from rr_ptr upward (mod N); first requester wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = (IW+1)'(rr_ptr) + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx_c = cand[IW-1:0];
      end
    end
    if (found) grant_c[idx_c] = 1'b1;
  end

  // Priority pointer: one past the last winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (idx_c == IW'(N - 1)) ? '0 : idx_c + IW'(1);
    end
  end

endmodule

// File: rtl/sma_mc_sched.sv
// Multi-channel SMA scheduler: round-robin picks one channel sample per
// cycle, S1 registers it with the history value it overwrites, S2 updates
// that channel's context and loads a channel-tagged window average into a
// valid/ready output register.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   in_valid   - per-channel sample valid
//   in_data    - per-channel sample
//   in_ready   - per-channel accept (combinational, at most one high)
//   ch_clear   - synchronous per-channel context clear
//   out_valid  - average valid (registered)
//   out_ready  - downstream accept
//   out_ch     - channel of out_data (registered)
//   out_data   - window average (registered)
// Context widths come from sma_pkg; change geometry there.
module sma_mc_sched
  import sma_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WINDOW     = DEF_WINDOW
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_CH-1:0]                in_valid,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]                in_ready,
  input  logic [NUM_CH-1:0]                ch_clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CH_W-1:0]                  out_ch,
  output logic [DATA_WIDTH-1:0]            out_data
);

  ch_ctx_t               ctx  [NUM_CH];
  logic [DATA_WIDTH-1:0] hist [NUM_CH][WINDOW];

  logic                  s1_valid;
  logic [CH_W-1:0]       s1_ch;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] s1_old;

  logic                  stall;
  logic                  hs;
  logic                  retire;
  logic                  emit;
  logic [NUM_CH-1:0]     s1_mask;
  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       gidx;
  ch_ctx_t               ctx_cur;
  logic [SUM_W-1:0]      sum_nxt;

  // Request qualification: same channel as S1 is excluded so a retiring
  // context is never read stale.
  always_comb begin
    stall   = out_valid & ~out_ready;
    s1_mask = '0;
    if (s1_valid) s1_mask[s1_ch] = 1'b1;
    eligible = in_valid & ~ch_clear & ~s1_mask & {NUM_CH{~stall}};
  end

  sma_rr_arb #(
    .N (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (eligible),
    .advance (hs),
    .grant_c (grant),
    .idx_c   (gidx)
  );

  assign in_ready = grant;
  assign hs       = |grant;

  // S2 update math; a clear on the S1 channel discards the retirement.
  always_comb begin
    ctx_cur = ctx[s1_ch];
    sum_nxt = ctx_cur.sum + SUM_W'(s1_data) - SUM_W'(s1_old);
    retire  = s1_valid & ~stall & ~ch_clear[s1_ch];
    emit    = retire & (ctx_cur.fill >= FILL_W'(WINDOW - 1));
  end

  // S1 capture; a stalled entry is dropped if its channel is cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_data  <= '0;
      s1_old   <= '0;
    end else if (!stall) begin
      s1_valid <= hs;
      if (hs) begin
        s1_ch   <= gidx;
        s1_data <= in_data[gidx];
        s1_old  <= hist[gidx][ctx[gidx].wptr];
      end
    end else if (s1_valid && ch_clear[s1_ch]) begin
      s1_valid <= 1'b0;
    end
  end

  // Per-channel context; clear wins over both stall and retirement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        ctx[i] <= '0;
        for (int j = 0; j < int'(WINDOW); j++) hist[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (ch_clear[i]) begin
          ctx[i] <= '0;
          for (int j = 0; j < int'(WINDOW); j++) hist[i][j] <= '0;
        end else if (retire && s1_ch == CH_W'(i)) begin
          ctx[i].sum  <= sum_nxt;
          ctx[i].wptr <= ctx[i].wptr + PTR_W'(1);
          if (ctx[i].fill < FILL_W'(WINDOW)) ctx[i].fill <= ctx[i].fill + FILL_W'(1);
          hist[i][ctx[i].wptr] <= s1_data;
        end
      end
    end
  end

  // Output register: holds until consumed; emit only occurs when not stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_ch    <= s1_ch;
      out_data  <= DATA_WIDTH'(sum_nxt >> PTR_W);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sma_mc_sched.sv
// Directed bench for sma_mc_sched: single-channel fill, interleaving,
// fairness, backpressure, max values and channel clear.
module tb_sma_mc_sched;

  logic             clk;
  logic             rstn;
  logic [3:0]       in_valid;
  logic [3:0][15:0] in_data;
  logic [3:0]       in_ready;
  logic [3:0]       ch_clear;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_ch;
  logic [15:0]      out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         oq_ch[$];
  int         oq_data[$];
  int         oq_cyc[$];
  logic [3:0] gq_vec[$];

  sma_mc_sched dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_clear  (ch_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record consumed outputs and grants, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        oq_ch.push_back(int'(out_ch));
        oq_data.push_back(int'(out_data));
        oq_cyc.push_back(cyc);
      end
      if (|in_ready) gq_vec.push_back(in_ready);
    end
  end

  task automatic clear_queues();
    oq_ch.delete(); oq_data.delete(); oq_cyc.delete(); gq_vec.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = '0; ch_clear = '0; out_ready = 1'b1; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    clear_queues();
  endtask

  // Offer one sample on channel c and wait for its handshake; hc = handshake cycle.
  task automatic send(input int c, input logic [15:0] d, output int hc);
    int n;
    n = 0;
    in_valid[c] = 1'b1;
    in_data[c]  = d;
    @(negedge clk);
    while (!in_ready[c] && n < 40) begin
      @(negedge clk);
      n++;
    end
    hc = cyc;
    if (!in_ready[c]) begin
      total++; bad++;
      $display("FAIL send_timeout ch%0d: in_ready=0 required 1", c);
    end
    @(posedge clk);
    #1 in_valid[c] = 1'b0;
  endtask

  task automatic check_out(input string nm, input int k, input int ech, input int edata, input int ecyc);
    total++;
    if (k >= oq_ch.size()) begin
      bad++; $display("FAIL %s: output %0d missing, have %0d outputs", nm, k, oq_ch.size());
    end else if (oq_ch[k] !== ech || oq_data[k] !== edata || (ecyc >= 0 && oq_cyc[k] !== ecyc)) begin
      bad++;
      $display("FAIL %s[%0d]: got ch=%0d data=%0d cyc=%0d expected ch=%0d data=%0d cyc=%0d",
               nm, k, oq_ch[k], oq_data[k], oq_cyc[k], ech, edata, ecyc);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = '0; ch_clear = '0; out_ready = 1'b1; in_data = '0;
    @(negedge clk);
    total++; if (in_ready !== 4'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch: got %0d expected 0", out_ch); end
    total++; if (out_data !== 16'd0) begin bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    @(posedge clk);
    #1 rstn = 1'b1;
    clear_queues();
  endtask

  task automatic test_single_fill();
    int h[5];
    do_reset();
    for (int k = 0; k < 5; k++) send(0, 16'(4 * (k + 1)), h[k]);
    repeat (4) @(negedge clk);
    for (int k = 1; k < 5; k++) begin
      total++;
      if (h[k] - h[k-1] !== 2) begin
        bad++; $display("FAIL single_spacing[%0d]: got %0d cycles expected 2", k, h[k] - h[k-1]);
      end
    end
    total++;
    if (oq_ch.size() !== 2) begin bad++; $display("FAIL single_count: got %0d expected 2", oq_ch.size()); end
    check_out("single_out", 0, 0, 10, h[3] + 2);
    check_out("single_out", 1, 0, 14, h[4] + 2);
  endtask

  task automatic test_interleave();
    int h0[4];
    int h1[4];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(0, 16'd100, h0[k]);
      send(1, (k == 3) ? 16'd400 : 16'd0, h1[k]);
    end
    repeat (4) @(negedge clk);
    total++;
    if (oq_ch.size() !== 2) begin bad++; $display("FAIL inter_count: got %0d expected 2", oq_ch.size()); end
    total++;
    if (h1[3] !== h0[3] + 1) begin bad++; $display("FAIL inter_rate: ch1 hs at %0d expected %0d", h1[3], h0[3] + 1); end
    check_out("inter_out", 0, 0, 100, h0[3] + 2);
    check_out("inter_out", 1, 1, 100, h1[3] + 2);
  endtask

  task automatic test_fairness();
    logic [3:0] exp_v;
    do_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) in_data[c] = 16'd7;
    in_valid = 4'hF;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 in_valid = '0;
    total++;
    if (gq_vec.size() < 12) begin
      bad++; $display("FAIL fair_count: got %0d grants expected at least 12", gq_vec.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        exp_v = 4'(1 << (k % 4));
        total++;
        if (gq_vec[k] !== exp_v) begin
          bad++; $display("FAIL fair_grant[%0d]: got %b expected %b", k, gq_vec[k], exp_v);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    int h[4];
    int hr;
    int n;
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 16'd10, h[k]);
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    total++;
    if (!out_valid || cyc !== h[3] + 2) begin
      bad++; $display("FAIL bp_load: out_valid=%b at cyc %0d expected 1 at %0d", out_valid, cyc, h[3] + 2);
    end
    in_data[0] = 16'd20;
    in_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 16'd10 || in_ready !== 4'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d data=%0d rdy=%b expected v=1 ch=0 data=10 rdy=0000",
                 k, out_valid, out_ch, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(0, 16'd20, hr);
    repeat (4) @(negedge clk);
    total++;
    if (oq_ch.size() !== 2) begin bad++; $display("FAIL bp_count: got %0d expected 2", oq_ch.size()); end
    check_out("bp_out", 0, 0, 10, hr);
    check_out("bp_out", 1, 0, 12, hr + 2);
  endtask

  task automatic test_max();
    int h[6];
    do_reset();
    for (int k = 0; k < 6; k++) send(2, 16'hFFFF, h[k]);
    repeat (4) @(negedge clk);
    total++;
    if (oq_ch.size() !== 3) begin bad++; $display("FAIL max_count: got %0d expected 3", oq_ch.size()); end
    for (int k = 0; k < 3; k++) check_out("max_out", k, 2, 65535, h[k + 3] + 2);
  endtask

  task automatic test_clear();
    int h[4];
    int hx;
    do_reset();
    for (int k = 0; k < 4; k++) send(0, 16'd10, h[k]);
    send(0, 16'd50, hx);
    ch_clear[0] = 1'b1;
    @(posedge clk);
    #1 ch_clear[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 16'd20, h[k]);
    repeat (4) @(negedge clk);
    total++;
    if (oq_ch.size() !== 2) begin bad++; $display("FAIL clear_count: got %0d expected 2", oq_ch.size()); end
    check_out("clear_out", 0, 0, 10, -1);
    check_out("clear_out", 1, 0, 20, h[3] + 2);
  endtask

  initial begin
    in_valid = '0; in_data = '0; ch_clear = '0; out_ready = 1'b1; rstn = 1'b0;
    test_reset();
    test_single_fill();
    test_interleave();
    test_fairness();
    test_backpressure();
    test_max();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
